// File: rtl/bomb_pkg.sv
// ============================================================================
// Module      : bomb_pkg
// Description : Shared types and constants for the per-player bomb manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } slot_state_t;

    localparam int         TILE_SIZE_DEF   = 40;
    localparam int         COORD_W_DEF     = 6;
    localparam logic [7:0] PLACE_KEY_SPACE = 8'd44;
    localparam logic [7:0] PLACE_KEY_KP0   = 8'd98;

    typedef logic [COORD_W_DEF-1:0] tile_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bomb_slot.sv
// ============================================================================
// Module      : bomb_slot
// Description : One bomb slot: IDLE/FUSE/BLAST FSM, tick counter and tile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bomb_slot
    import bomb_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int FUSE_TICKS  = 120,
    parameter int BLAST_TICKS = 30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               alloc_i,
    input  logic [COORD_W-1:0] tx_i,
    input  logic [COORD_W-1:0] ty_i,
    input  logic               tick_i,
    input  logic               chain_hit_i,
    output slot_state_t        state_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               blast_start_o
);

    localparam int CNT_W = $clog2(max2(FUSE_TICKS, BLAST_TICKS) + 1);

    slot_state_t        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               blast_start_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            blast_start_q <= 1'b0;
        end else begin
            blast_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (alloc_i) begin
                        state_q <= FUSE;
                        cnt_q   <= CNT_W'(FUSE_TICKS);
                        x_q     <= tx_i;
                        y_q     <= ty_i;
                    end
                end
                FUSE: begin
                    // A chain hit wins over a tick landing in the same cycle.
                    if (chain_hit_i || (tick_i && cnt_q == CNT_W'(1))) begin
                        state_q       <= BLAST;
                        cnt_q         <= CNT_W'(BLAST_TICKS);
                        blast_start_q <= 1'b1;
                    end else if (tick_i) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                BLAST: begin
                    if (tick_i) begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state_o       = state_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign blast_start_o = blast_start_q;

endmodule

`default_nettype wire

// File: rtl/bomb_manager.sv
// ============================================================================
// Module      : bomb_manager
// Description : Per-player bomb slot manager: key detect, tile mapping,
//               lowest-free-slot allocation and per-slot fuse/blast timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bomb_manager
    import bomb_pkg::*;
#(
    parameter int         NUM_SLOTS    = 4,
    parameter int         NUM_KEYS     = 4,
    parameter int         TILE_SIZE    = TILE_SIZE_DEF,
    parameter int         COORD_W      = COORD_W_DEF,
    parameter int         FUSE_TICKS   = 120,
    parameter int         BLAST_TICKS  = 30,
    parameter logic [7:0] PLACE_KEY_P0 = PLACE_KEY_SPACE,
    parameter logic [7:0] PLACE_KEY_P1 = PLACE_KEY_KP0
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [8*NUM_KEYS-1:0]          keys,
    input  logic                           player_id,
    input  logic [9:0]                     pos_x,
    input  logic [9:0]                     pos_y,
    input  logic                           tick,
    input  logic [$clog2(NUM_SLOTS+1)-1:0] max_bombs,
    input  logic [NUM_SLOTS-1:0]           chain_hit,
    output logic [NUM_SLOTS*COORD_W-1:0]   bomb_x,
    output logic [NUM_SLOTS*COORD_W-1:0]   bomb_y,
    output logic [NUM_SLOTS-1:0]           bomb_fuse,
    output logic [NUM_SLOTS-1:0]           bomb_blast,
    output logic [NUM_SLOTS-1:0]           blast_start,
    output logic                           place_ack,
    output logic                           place_reject
);

    localparam int MB_W = $clog2(NUM_SLOTS + 1);

    logic [7:0]         place_key;
    logic               hit;
    logic               hit_q;
    logic               press;
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    logic               found;
    logic               dup;
    logic               accept;
    logic [NUM_SLOTS-1:0] cand_oh;
    logic [NUM_SLOTS-1:0] alloc_vec;

    slot_state_t        slot_state [NUM_SLOTS];
    logic [COORD_W-1:0] slot_x     [NUM_SLOTS];
    logic [COORD_W-1:0] slot_y     [NUM_SLOTS];

    assign place_key = player_id ? PLACE_KEY_P1 : PLACE_KEY_P0;

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keys[k*8 +: 8] == place_key) begin
                hit = 1'b1;
            end
        end
    end

    assign press = hit & ~hit_q;
    assign tx    = COORD_W'(pos_x / 10'(TILE_SIZE));
    assign ty    = COORD_W'(pos_y / 10'(TILE_SIZE));

    // Only the registered slot state is consulted, so a slot freed this cycle
    // becomes a candidate one cycle later.
    always_comb begin
        found   = 1'b0;
        dup     = 1'b0;
        cand_oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && slot_state[i] == IDLE && MB_W'(i) < max_bombs) begin
                found      = 1'b1;
                cand_oh[i] = 1'b1;
            end
            if (slot_state[i] != IDLE && slot_x[i] == tx && slot_y[i] == ty) begin
                dup = 1'b1;
            end
        end
    end

    assign accept    = press & found & ~dup;
    assign alloc_vec = accept ? cand_oh : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit_q        <= 1'b0;
            place_ack    <= 1'b0;
            place_reject <= 1'b0;
        end else begin
            hit_q        <= hit;
            place_ack    <= accept;
            place_reject <= press & ~accept;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            bomb_slot #(
                .COORD_W    (COORD_W),
                .FUSE_TICKS (FUSE_TICKS),
                .BLAST_TICKS(BLAST_TICKS)
            ) u_slot (
                .clk_i        (Clk),
                .rst_i        (Reset),
                .alloc_i      (alloc_vec[i]),
                .tx_i         (tx),
                .ty_i         (ty),
                .tick_i       (tick),
                .chain_hit_i  (chain_hit[i]),
                .state_o      (slot_state[i]),
                .x_o          (slot_x[i]),
                .y_o          (slot_y[i]),
                .blast_start_o(blast_start[i])
            );

            assign bomb_x[i*COORD_W +: COORD_W] = slot_x[i];
            assign bomb_y[i*COORD_W +: COORD_W] = slot_y[i];
            assign bomb_fuse[i]                 = (slot_state[i] == FUSE);
            assign bomb_blast[i]                = (slot_state[i] == BLAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bomb_manager.sv
// ============================================================================
// Module      : tb_bomb_manager
// Description : Directed self-checking bench for bomb_manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bomb_manager;

    localparam int NS = 4;
    localparam int CW = 6;

    logic            Clk;
    logic            Reset;
    logic [31:0]     keys;
    logic            player_id;
    logic [9:0]      pos_x;
    logic [9:0]      pos_y;
    logic            tick;
    logic [2:0]      max_bombs;
    logic [NS-1:0]   chain_hit;
    logic [NS*CW-1:0] bomb_x;
    logic [NS*CW-1:0] bomb_y;
    logic [NS-1:0]   bomb_fuse;
    logic [NS-1:0]   bomb_blast;
    logic [NS-1:0]   blast_start;
    logic            place_ack;
    logic            place_reject;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] KEY_SPACE_B2 = 32'h002C_0000;

    bomb_manager #(
        .NUM_SLOTS  (NS),
        .NUM_KEYS   (4),
        .TILE_SIZE  (40),
        .COORD_W    (CW),
        .FUSE_TICKS (3),
        .BLAST_TICKS(2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .keys        (keys),
        .player_id   (player_id),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .tick        (tick),
        .max_bombs   (max_bombs),
        .chain_hit   (chain_hit),
        .bomb_x      (bomb_x),
        .bomb_y      (bomb_y),
        .bomb_fuse   (bomb_fuse),
        .bomb_blast  (bomb_blast),
        .blast_start (blast_start),
        .place_ack   (place_ack),
        .place_reject(place_reject)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        keys      = '0;
        tick      = 1'b0;
        chain_hit = '0;
        Reset     = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
        cyc();
    endtask

    // Single-cycle press followed by one released cycle.
    task automatic press(input logic [9:0] px, input logic [9:0] py,
                         output logic ack, output logic rej);
        pos_x = px;
        pos_y = py;
        keys  = KEY_SPACE_B2;
        cyc();
        ack  = place_ack;
        rej  = place_reject;
        keys = '0;
        cyc();
    endtask

    initial begin
        logic ack, rej;
        int   acks, rejs;

        Reset     = 1'b1;
        keys      = '0;
        player_id = 1'b0;
        pos_x     = '0;
        pos_y     = '0;
        tick      = 1'b0;
        max_bombs = 3'd4;
        chain_hit = '0;
        cyc();
        cyc();
        Reset = 1'b0;
        cyc();

        check_eq("rst_fuse",  32'(bomb_fuse),   32'h0);
        check_eq("rst_blast", 32'(bomb_blast),  32'h0);
        check_eq("rst_start", 32'(blast_start), 32'h0);
        check_eq("rst_x",     32'(bomb_x),      32'h0);
        check_eq("rst_y",     32'(bomb_y),      32'h0);
        check_eq("rst_ack",   32'(place_ack),   32'h0);
        check_eq("rst_rej",   32'(place_reject),32'h0);

        // Player 1 key while player 0 is selected: no press.
        keys = 32'h0000_0062;
        cyc();
        check_eq("wrongkey_ack", 32'(place_ack), 32'h0);
        keys = '0;
        cyc();

        // Held key, five cycles, pixel (85,130) -> tile (2,3).
        pos_x = 10'd85;
        pos_y = 10'd130;
        keys  = KEY_SPACE_B2;
        acks  = 0;
        rejs  = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            acks += int'(place_ack);
            rejs += int'(place_reject);
        end
        keys = '0;
        cyc();
        check_eq("held_acks", 32'(acks), 32'd1);
        check_eq("held_rejs", 32'(rejs), 32'd0);
        check_eq("t1_fuse",   32'(bomb_fuse), 32'h1);
        check_eq("t1_x0",     32'(bomb_x[0 +: CW]), 32'd2);
        check_eq("t1_y0",     32'(bomb_y[0 +: CW]), 32'd3);

        do_tick();
        do_tick();
        check_eq("t1_fuse_2ticks", 32'(bomb_fuse), 32'h1);
        do_tick();
        check_eq("t1_blast",  32'(bomb_blast),  32'h1);
        check_eq("t1_start",  32'(blast_start), 32'h1);
        check_eq("t1_fuse_off", 32'(bomb_fuse), 32'h0);
        cyc();
        check_eq("t1_start_pulse", 32'(blast_start), 32'h0);
        do_tick();
        check_eq("t1_blast_1tick", 32'(bomb_blast), 32'h1);
        do_tick();
        check_eq("t1_idle_blast", 32'(bomb_blast), 32'h0);
        check_eq("t1_idle_fuse",  32'(bomb_fuse),  32'h0);
        check_eq("t1_x_hold",     32'(bomb_x[0 +: CW]), 32'd2);

        // Fill all four slots, fifth press refused.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            press(10'(s * 40), 10'd0, ack, rej);
            check_eq($sformatf("fill_ack%0d", s), 32'(ack), 32'h1);
        end
        check_eq("fill_fuse", 32'(bomb_fuse), 32'hF);
        check_eq("fill_x3",   32'(bomb_x[3*CW +: CW]), 32'd3);
        press(10'd160, 10'd0, ack, rej);
        check_eq("full_rej", 32'(rej), 32'h1);
        check_eq("full_ack", 32'(ack), 32'h0);
        check_eq("full_fuse", 32'(bomb_fuse), 32'hF);

        // Allowance of two.
        do_reset();
        max_bombs = 3'd2;
        press(10'd0,  10'd0, ack, rej);
        press(10'd40, 10'd0, ack, rej);
        check_eq("mb2_ack2", 32'(ack), 32'h1);
        press(10'd80, 10'd0, ack, rej);
        check_eq("mb2_rej3", 32'(rej), 32'h1);
        check_eq("mb2_fuse", 32'(bomb_fuse), 32'h3);

        // Allowance of zero.
        max_bombs = 3'd0;
        press(10'd200, 10'd0, ack, rej);
        check_eq("mb0_rej", 32'(rej), 32'h1);

        // Duplicate tile.
        do_reset();
        max_bombs = 3'd4;
        press(10'd85, 10'd130, ack, rej);
        press(10'd99, 10'd159, ack, rej);
        check_eq("dup_rej",  32'(rej), 32'h1);
        check_eq("dup_fuse", 32'(bomb_fuse), 32'h1);

        // Chain hit on slot 1 together with a tick.
        press(10'd0, 10'd0, ack, rej);
        check_eq("chain_setup", 32'(bomb_fuse), 32'h3);
        chain_hit = 4'b0010;
        tick      = 1'b1;
        cyc();
        chain_hit = '0;
        tick      = 1'b0;
        check_eq("chain_blast", 32'(bomb_blast),  32'h2);
        check_eq("chain_start", 32'(blast_start), 32'h2);
        check_eq("chain_fuse",  32'(bomb_fuse),   32'h1);
        cyc();
        check_eq("chain_start_pulse", 32'(blast_start), 32'h0);
        do_tick();
        check_eq("chain_blast_hold", 32'(bomb_blast), 32'h2);
        do_tick();
        check_eq("chain_end_blast", 32'(bomb_blast),  32'h1);
        check_eq("chain_end_start", 32'(blast_start), 32'h1);
        check_eq("chain_end_fuse",  32'(bomb_fuse),   32'h0);

        // Slot 0 leaves BLAST in the press cycle while 1..3 are busy.
        do_reset();
        press(10'd0, 10'd0, ack, rej);
        do_tick();
        do_tick();
        do_tick();
        press(10'd40,  10'd0, ack, rej);
        press(10'd80,  10'd0, ack, rej);
        press(10'd120, 10'd0, ack, rej);
        check_eq("race_setup_fuse",  32'(bomb_fuse),  32'hE);
        check_eq("race_setup_blast", 32'(bomb_blast), 32'h1);
        do_tick();
        pos_x = 10'd200;
        pos_y = 10'd0;
        keys  = KEY_SPACE_B2;
        tick  = 1'b1;
        cyc();
        tick = 1'b0;
        keys = '0;
        check_eq("race_rej",   32'(place_reject), 32'h1);
        check_eq("race_blast", 32'(bomb_blast),   32'h0);
        check_eq("race_fuse",  32'(bomb_fuse),    32'hE);
        cyc();
        keys = KEY_SPACE_B2;
        cyc();
        keys = '0;
        check_eq("repress_ack", 32'(place_ack), 32'h1);
        check_eq("repress_fuse", 32'(bomb_fuse), 32'hF);
        check_eq("repress_x0",  32'(bomb_x[0 +: CW]), 32'd5);
        cyc();

        // Asynchronous reset while slots 0 and 2 are in FUSE.
        do_reset();
        press(10'd0,  10'd0, ack, rej);
        press(10'd40, 10'd0, ack, rej);
        press(10'd80, 10'd0, ack, rej);
        chain_hit = 4'b0010;
        cyc();
        chain_hit = '0;
        do_tick();
        do_tick();
        check_eq("arst_setup_fuse",  32'(bomb_fuse),  32'h5);
        check_eq("arst_setup_blast", 32'(bomb_blast), 32'h0);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("arst_fuse",  32'(bomb_fuse),   32'h0);
        check_eq("arst_blast", 32'(bomb_blast),  32'h0);
        check_eq("arst_start", 32'(blast_start), 32'h0);
        check_eq("arst_x",     32'(bomb_x),      32'h0);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check_eq("arst_start_held", 32'(blast_start), 32'h0);
        Reset = 1'b0;
        cyc();
        press(10'd85, 10'd130, ack, rej);
        check_eq("post_rst_ack",  32'(ack), 32'h1);
        check_eq("post_rst_fuse", 32'(bomb_fuse), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
